cdb_broadcast_arbiter: RTL
==========================

Name: cdb_broadcast_arbiter

Overview:
Write-back end of the Common Data Bus. It collects completed results from the functional units, where each unit presents a tag Q and data under a write-enable handshake. It holds one pending result per source and grants one per cycle using round-robin. The winner is driven onto the registered CDB broadcast (Qi_CDB / Qi_CDB_data) that register_status and the reservation stations snoop. It replaces the current free-running CDB_arbiter stub.

Parameters:
N_SRC, 2, number of functional-unit write-back sources (index 0 = ADD1 unit, 1 = ADD2 unit).
TAG_W, 4, width of a reservation-station tag; tag 0 = FREE_REGISTER, meaning no producer.
DATA_W, 16, result data width.
IDLE_DATA, 16'hFFF0, value driven on Qi_CDB_data when nothing is broadcast (sem_valor).

Ports:
Clock  in  1  system clock, rising edge.
Reset  in  1  asynchronous, active-low reset.
Wb_Valid  in  N_SRC  per-source write request (the FU's Write_Enable_CDB).
Wb_Tag  in  N_SRC*TAG_W  per-source producer tag; source i occupies bits [i*TAG_W +: TAG_W].
Wb_Data  in  N_SRC*DATA_W  per-source result; source i occupies bits [i*DATA_W +: DATA_W].
Wb_Ready  out  N_SRC  per-source accept; a transfer occurs on a rising edge where Wb_Valid[i] & Wb_Ready[i].
Qi_CDB  out  TAG_W  broadcast tag; 0 when idle.
Qi_CDB_data  out  DATA_W  broadcast data.
CDB_Valid  out  1  broadcast valid this cycle.
Grant  out  N_SRC  one-hot: source whose result is on the bus this cycle (frees that RS); all 0 when idle.
Pending  out  N_SRC  holding-register occupancy, for debug and for stall logic.

Behaviour:
- Reset (Reset=0, asynchronous):
  - held[] = 0, rr_ptr = 0.
  - CDB_Valid = 0, Qi_CDB = 0, Qi_CDB_data = IDLE_DATA, Grant = 0.
  - Reset mid-operation discards all pending results; there is no replay.
- Wb_Ready[i] = ~held[i], purely combinational from state. Each source has exactly one holding slot.
- Accept: on an edge with Wb_Valid[i] & Wb_Ready[i] and Wb_Tag_i != 0, set held[i] and capture tag and data.
  - Wb_Tag_i == 0 is accepted but dropped: held stays 0 and nothing is broadcast.
- Arbitration, combinational over the held[] value at the start of the cycle:
  - Search from index rr_ptr upward, modulo N_SRC.
  - The first held entry is the winner g.
- On each rising edge:
  - If any entry is held: register CDB_Valid=1, Qi_CDB=tag[g], Qi_CDB_data=data[g], Grant=onehot(g); clear held[g]; rr_ptr = (g+1) mod N_SRC.
  - Otherwise: CDB_Valid=0, Qi_CDB=0, Qi_CDB_data=IDLE_DATA, Grant=0; rr_ptr unchanged.
- Broadcast lasts exactly one cycle per result; outputs are fully registered.
- Latency:
  - A request accepted at edge k is eligible at edge k+1.
  - With no contention it is on the bus during cycle k+1 to k+2.
  - Worst case under contention: on the bus within N_SRC cycles after acceptance. No starvation.
- Per-source throughput is one result every 2 cycles: the slot clears at the grant edge, so Wb_Ready returns 1 after that edge.
- Simultaneous events:
  - Accept and grant of the same source never coincide, because Wb_Ready=0 while held.
  - Accepts from other sources on the grant edge are captured normally.
- A source whose Wb_Valid is high while held stays blocked. The FU must keep tag and data stable until accepted.
- Duplicate tags from two sources are broadcast in arbitration order; no check is made.
- Pending = held[].

Decomposition:
- Shared package tomasulo_pkg:
  - TAG_W, DATA_W.
  - Tag constants FREE_REGISTER=0, RES_STATION_ADD1=1, RES_STATION_ADD2=2.
  - SEM_VALOR=16'hFFF0.
  - Source index constants SRC_ADD1=0, SRC_ADD2=1.
- One sub-module rr_priority_picker: combinational; inputs req[N_SRC] and ptr; outputs onehot grant and index. It is reusable for the dispatch-side RS selection.

Test Plan:
- Reset: hold Reset=0 mid-run with held=2'b11, then release -> CDB_Valid=0, Qi_CDB=0, Qi_CDB_data=16'hFFF0, Wb_Ready=2'b11, first later grant goes to source 0.
- Single source: src0 tag=1, data=16'h0007 accepted at edge k -> edge k+1 gives CDB_Valid=1, Qi_CDB=1, data=0007, Grant=01; at edge k+2 the bus is idle.
- Contention: both accepted on the same edge (tag 1 / 16'h0003, tag 2 / 16'h0005) with rr_ptr=0 -> tag 1 broadcast, then tag 2 on the next cycle; rr_ptr ends at 0.
- Fairness: both sources request back-to-back continuously for 8 grants -> Grant alternates 01, 10, 01, ...; neither source waits more than 2 cycles after acceptance.
- Backpressure: src1 re-asserts Wb_Valid while held -> Wb_Ready[1]=0, second payload not captured until after its grant, and the first payload is broadcast unaltered.
- Tag 0: Wb_Valid[0]=1 with Wb_Tag=0 -> Pending stays 00 and CDB_Valid stays 0.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// ============================================================================
// Module   : tomasulo_pkg
// Purpose  : Shared widths, tag encodings and source indices for the
//            Tomasulo write-back path (CDB arbiter, RS dispatch).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tomasulo_pkg;

    // Datapath widths
    localparam int TAG_W  = 4;
    localparam int DATA_W = 16;

    // Reservation-station tags; FREE_REGISTER means "no producer"
    localparam logic [TAG_W-1:0] FREE_REGISTER    = 4'd0;
    localparam logic [TAG_W-1:0] RES_STATION_ADD1 = 4'd1;
    localparam logic [TAG_W-1:0] RES_STATION_ADD2 = 4'd2;

    // Value left on the CDB data lines when nothing is broadcast
    localparam logic [DATA_W-1:0] SEM_VALOR = 16'hFFF0;

    // Write-back source indices
    localparam int SRC_ADD1 = 0;
    localparam int SRC_ADD2 = 1;

endpackage : tomasulo_pkg

`default_nettype wire

// File: rtl/rr_priority_picker.sv
// ============================================================================
// Module   : rr_priority_picker
// Purpose  : Combinational round-robin picker. Scans the request vector
//            starting at ptr_i (wrapping modulo N) and returns the first
//            requester as a one-hot grant plus its binary index.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_picker #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // Walk the requests from the pointer upward, keeping the first hit
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] k;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        k       = '0;
        for (int off = 0; off < N; off++) begin
            k = IDX_W'((int'(ptr_i) + off) % N);
            if (!found && req_i[k]) begin
                found      = 1'b1;
                grant_o[k] = 1'b1;
                idx_o      = k;
            end
        end
        valid_o = found;
    end

endmodule : rr_priority_picker

`default_nettype wire

// File: rtl/cdb_broadcast_arbiter.sv
// ============================================================================
// Module   : cdb_broadcast_arbiter
// Purpose  : Common Data Bus write-back arbiter. One holding slot per
//            functional unit; one registered broadcast per cycle chosen
//            round-robin among occupied slots.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdb_broadcast_arbiter #(
    parameter int                N_SRC     = 2,
    parameter int                TAG_W     = tomasulo_pkg::TAG_W,
    parameter int                DATA_W    = tomasulo_pkg::DATA_W,
    parameter logic [DATA_W-1:0] IDLE_DATA = tomasulo_pkg::SEM_VALOR
) (
    input  logic                      Clock_i,
    input  logic                      Reset_ni,
    input  logic [N_SRC-1:0]          Wb_Valid_i,
    input  logic [N_SRC*TAG_W-1:0]    Wb_Tag_i,
    input  logic [N_SRC*DATA_W-1:0]   Wb_Data_i,
    output logic [N_SRC-1:0]          Wb_Ready_o,
    output logic [TAG_W-1:0]          Qi_CDB_o,
    output logic [DATA_W-1:0]         Qi_CDB_data_o,
    output logic                      CDB_Valid_o,
    output logic [N_SRC-1:0]          Grant_o,
    output logic [N_SRC-1:0]          Pending_o
);

    import tomasulo_pkg::*;

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    // Holding slots and round-robin pointer
    logic [N_SRC-1:0]  held_q, held_d;
    logic [TAG_W-1:0]  tag_q  [N_SRC];
    logic [DATA_W-1:0] data_q [N_SRC];
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;

    // Registered broadcast
    logic              cdb_valid_q;
    logic [TAG_W-1:0]  qi_q;
    logic [DATA_W-1:0] qd_q;
    logic [N_SRC-1:0]  grant_q;

    logic [N_SRC-1:0]  w_accept;
    logic [N_SRC-1:0]  w_pick_gnt;
    logic [IDX_W-1:0]  w_pick_idx;
    logic              w_pick_vld;

    assign Wb_Ready_o    = ~held_q;
    assign Pending_o     = held_q;
    assign CDB_Valid_o   = cdb_valid_q;
    assign Qi_CDB_o      = qi_q;
    assign Qi_CDB_data_o = qd_q;
    assign Grant_o       = grant_q;

    // A handshake with a FREE_REGISTER tag completes but is not stored
    generate
        for (genvar i = 0; i < N_SRC; i++) begin : g_accept
            assign w_accept[i] = Wb_Valid_i[i] & ~held_q[i]
                               & (Wb_Tag_i[i*TAG_W +: TAG_W] != FREE_REGISTER);
        end
    endgenerate

    rr_priority_picker #(
        .N     (N_SRC),
        .IDX_W (IDX_W)
    ) u_picker (
        .req_i   (held_q),
        .ptr_i   (rr_ptr_q),
        .grant_o (w_pick_gnt),
        .idx_o   (w_pick_idx),
        .valid_o (w_pick_vld)
    );

    // Next occupancy and pointer: winner's slot frees, new accepts fill
    always_comb begin
        held_d   = (held_q & ~w_pick_gnt) | w_accept;
        rr_ptr_d = rr_ptr_q;
        if (w_pick_vld) begin
            rr_ptr_d = (w_pick_idx == IDX_W'(N_SRC - 1)) ? '0 : w_pick_idx + 1'b1;
        end
    end

    // Slot capture, occupancy and pointer state
    always_ff @(posedge Clock_i or negedge Reset_ni) begin
        if (!Reset_ni) begin
            held_q   <= '0;
            rr_ptr_q <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            held_q   <= held_d;
            rr_ptr_q <= rr_ptr_d;
            for (int i = 0; i < N_SRC; i++) begin
                if (w_accept[i]) begin
                    tag_q[i]  <= Wb_Tag_i[i*TAG_W +: TAG_W];
                    data_q[i] <= Wb_Data_i[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Broadcast register: winner for one cycle, idle pattern otherwise
    always_ff @(posedge Clock_i or negedge Reset_ni) begin
        if (!Reset_ni) begin
            cdb_valid_q <= 1'b0;
            qi_q        <= FREE_REGISTER;
            qd_q        <= IDLE_DATA;
            grant_q     <= '0;
        end else if (w_pick_vld) begin
            cdb_valid_q <= 1'b1;
            qi_q        <= tag_q[w_pick_idx];
            qd_q        <= data_q[w_pick_idx];
            grant_q     <= w_pick_gnt;
        end else begin
            cdb_valid_q <= 1'b0;
            qi_q        <= FREE_REGISTER;
            qd_q        <= IDLE_DATA;
            grant_q     <= '0;
        end
    end

endmodule : cdb_broadcast_arbiter

`default_nettype wire
